negser: RTL

//  Parametrised, limb-serial two's-complement negate/absolute-value unit with valid/ready handshakes.

---
 rtl/negser_pkg.sv | 35 +++
 rtl/negser_condinc.sv | 22 ++
 rtl/negser.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/negser_pkg.sv
// Shared types for the limb-serial negate/absolute-value unit.
//   negmode_t  : operation select carried on the mode port
//   negstate_t : control FSM state encoding
//   mode_inv() : whether an operation in the given mode inverts its operand
package negpkg;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        NEG  = 2'd1,
        ABS  = 2'd2,
        NABS = 2'd3
    } negmode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } negstate_t;

    // Invert-and-increment is applied to the whole operand when this returns 1.
    // ABS negates only negative inputs, NABS only non-negative ones.
    function automatic logic mode_inv(input negmode_t mode, input logic asign);
        logic inv;
        inv = 1'b0;
        case (mode)
            PASS:    inv = 1'b0;
            NEG:     inv = 1'b1;
            ABS:     inv = asign;
            NABS:    inv = ~asign;
            default: inv = 1'b0;
        endcase
        return inv;
    endfunction

endpackage

// File: rtl/negser_condinc.sv
// Combinational conditional-invert-plus-carry slice for one limb.
//   limb : LIMB-bit operand slice
//   inv  : invert the slice before adding
//   cin  : carry into the slice
//   r    : LIMB-bit sum
//   cout : carry out of the slice
module condinc #(
    parameter int unsigned LIMB = 16
) (
    input  logic [LIMB-1:0] limb,
    input  logic            inv,
    input  logic            cin,
    output logic [LIMB-1:0] r,
    output logic            cout
);

    logic [LIMB-1:0] opnd;

    assign opnd      = inv ? ~limb : limb;
    assign {cout, r} = {1'b0, opnd} + {{LIMB{1'b0}}, cin};

endmodule

// File: rtl/negser.sv
// Limb-serial two's-complement negate / absolute-value unit.
// Processes LIMB bits per cycle, least significant limb first, over a WIDTH-bit operand,
// with valid/ready handshakes on both sides.
//   clk       : clock, all state on rising edge
//   reset_n   : asynchronous active-low reset
//   flush     : synchronous abort of any operation in flight
//   in_valid  : operand/mode valid
//   in_ready  : unit idle and able to accept an operand
//   a         : WIDTH-bit operand
//   mode      : PASS (y=a), NEG (y=-a), ABS (y=|a|), NABS (y=-|a|)
//   out_valid : result valid
//   out_ready : consumer accepts result
//   y         : WIDTH-bit result, mod 2^WIDTH
//   ovf       : result not representable (negating the most negative value)
//   zero      : y == 0
module negser
    import negpkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LIMB  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  negmode_t         mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N    = WIDTH / LIMB;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % LIMB) != 0) begin : g_bad_limb
        $error("negser: WIDTH (%0d) must be a multiple of LIMB (%0d)", WIDTH, LIMB);
    end

    negstate_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // One register holds both operand and result: the operand drains out of the LSB end
    // while result limbs enter at the MSB end, so after N steps it holds the full result.
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] sh_next;
    logic             carry_q, carry_d;
    logic             inv_q, inv_d;
    logic             asign_q, asign_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [LIMB-1:0]  limb_r;
    logic             limb_c;
    logic             cap_inv;

    assign cap_inv = mode_inv(mode, a[WIDTH-1]);

    condinc #(
        .LIMB (LIMB)
    ) u_condinc (
        .limb (sh_q[LIMB-1:0]),
        .inv  (inv_q),
        .cin  (carry_q),
        .r    (limb_r),
        .cout (limb_c)
    );

    if (N == 1) begin : g_single
        assign sh_next = limb_r;
    end else begin : g_multi
        assign sh_next = {limb_r, sh_q[WIDTH-1:LIMB]};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        carry_d = carry_q;
        inv_d   = inv_q;
        asign_d = asign_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    sh_d    = a;
                    asign_d = a[WIDTH-1];
                    inv_d   = cap_inv;
                    // Seeding the carry with inv turns ~a into ~a + 1.
                    carry_d = cap_inv;
                end
            end
            BUSY: begin
                sh_d    = sh_next;
                carry_d = limb_c;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    // Outputs are only updated here, so they hold across the next operation.
                    y_d     = sh_next;
                    ovf_d   = inv_q & asign_q & sh_next[WIDTH-1];
                    zero_d  = ~|sh_next;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides accept, limb steps and result hand-off; no result is published.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            y_d     = y_q;
            ovf_d   = ovf_q;
            zero_d  = zero_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            sh_q    <= '0;
            carry_q <= 1'b0;
            inv_q   <= 1'b0;
            asign_q <= 1'b0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            carry_q <= carry_d;
            inv_q   <= inv_d;
            asign_q <= asign_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    a_ready_valid_excl: assert property (
        @(posedge clk) disable iff (!reset_n) !(in_ready && out_valid)
    );

    a_result_held: assert property (
        @(posedge clk) disable iff (!reset_n)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(y) && $stable(ovf)
                                                 && $stable(zero))
    );

endmodule
